// File: rtl/d_alu.sv
// d_alu: 8-bit registered ALU with carry and zero status.
// Result and carry are registered one cycle after op/A/B are sampled.
// ZERO is decoded from the registered result.
// Optional feature: define DALU_SHR_EN to add logical shift-right on op 8.
// Without DALU_SHR_EN, op 8 returns 0 like the other undefined ops.
module d_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] op,
  output logic [7:0] out,
  output logic [1:0] flags
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(7);
`ifdef DALU_SHR_EN
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(8);
`endif

  logic [DATA_W-1:0] result_c;
  logic              carry_c;
  logic [DATA_W:0]   sum_c;
  logic              carry_q;

  // Unsigned 9-bit sum; bit 8 is the ADD carry.
  assign sum_c = (DATA_W+1)'(A) + (DATA_W+1)'(B);

  // Decode op into the next result and carry; undefined ops give 0/0.
  always_comb begin
    result_c = '0;
    carry_c  = 1'b0;
    case (op)
      OP_OR:   result_c = A | B;
      OP_AND:  result_c = A & B;
      OP_XOR:  result_c = A ^ B;
      OP_NOT:  result_c = ~A;
      OP_ADD: begin
        result_c = sum_c[DATA_W-1:0];
        carry_c  = sum_c[DATA_W];
      end
      OP_SHL: begin
        result_c = {A[DATA_W-2:0], 1'b0};
        carry_c  = A[DATA_W-1];
      end
      OP_PASS: result_c = B;
`ifdef DALU_SHR_EN
      OP_SHR: begin
        result_c = {1'b0, A[DATA_W-1:1]};
        carry_c  = A[0];
      end
`endif
      default: begin
        result_c = '0;
        carry_c  = 1'b0;
      end
    endcase
  end

  // Result and carry registers; synchronous reset wins over any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      carry_q <= 1'b0;
    end else begin
      out     <= result_c;
      carry_q <= carry_c;
    end
  end

  // ZERO is the inverse of an any-bit-set reduction of the registered result.
  assign flags = {carry_q, ~(|out)};

endmodule

// File: tb/tb_d_alu.sv
// tb_d_alu: directed vectors with a scoreboard queue and a separate monitor.
module tb_d_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] op;
  logic [7:0] out;
  logic [1:0] flags;

  typedef struct {
    int         due;
    logic [7:0] exp_out;
    logic [1:0] exp_flags;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  d_alu dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .op    (op),
    .out   (out),
    .flags (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: results appear one cycle after issue; compare at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if (out !== e.exp_out) begin
        errors++;
        $display("FAIL %s out: got %02h expected %02h", e.name, out, e.exp_out);
      end
      checks++;
      if (flags !== e.exp_flags) begin
        errors++;
        $display("FAIL %s flags: got %02b expected %02b", e.name, flags, e.exp_flags);
      end
    end
  end

  task automatic issue(input logic r, input logic [3:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] eo,
                       input logic [1:0] ef, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    op  = o;
    A   = a;
    B   = b;
    e.due       = cyc + 1;
    e.exp_out   = eo;
    e.exp_flags = ef;
    e.name      = nm;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; op = 4'd0; A = 8'h00; B = 8'h00;
    // flags = {CARRY, ZERO}
    issue(1'b1, 4'd5, 8'hFA, 8'h07, 8'h00, 2'b01, "reset");
    issue(1'b0, 4'd1, 8'h02, 8'h03, 8'h03, 2'b00, "or_02_03");
    issue(1'b0, 4'd2, 8'h02, 8'h03, 8'h02, 2'b00, "and_02_03");
    issue(1'b0, 4'd2, 8'h02, 8'h05, 8'h00, 2'b01, "and_02_05");
    issue(1'b0, 4'd3, 8'h0F, 8'hF0, 8'hFF, 2'b00, "xor_0f_f0");
    issue(1'b0, 4'd3, 8'h55, 8'h55, 8'h00, 2'b01, "xor_55_55");
    issue(1'b0, 4'd4, 8'h0F, 8'hAA, 8'hF0, 2'b00, "not_0f");
    issue(1'b0, 4'd4, 8'hFF, 8'h00, 8'h00, 2'b01, "not_ff");
    issue(1'b0, 4'd5, 8'h02, 8'h03, 8'h05, 2'b00, "add_2_3");
    issue(1'b0, 4'd5, 8'd200, 8'd1, 8'd201, 2'b00, "add_200_1");
    issue(1'b0, 4'd5, 8'd250, 8'd7, 8'h01, 2'b10, "add_250_7");
    issue(1'b0, 4'd5, 8'h80, 8'h80, 8'h00, 2'b11, "add_80_80");
    issue(1'b0, 4'd6, 8'h10, 8'hFF, 8'h20, 2'b00, "shl_10");
    issue(1'b0, 4'd6, 8'h80, 8'h00, 8'h00, 2'b11, "shl_80");
    issue(1'b0, 4'd6, 8'hC1, 8'h00, 8'h82, 2'b10, "shl_c1");
    issue(1'b0, 4'd7, 8'h00, 8'h5A, 8'h5A, 2'b00, "pass_5a");
    issue(1'b0, 4'd7, 8'hFF, 8'h00, 8'h00, 2'b01, "pass_00");
    issue(1'b0, 4'd0, 8'hFF, 8'hFF, 8'h00, 2'b01, "op0_ff");
    issue(1'b0, 4'd15, 8'hFF, 8'h01, 8'h00, 2'b01, "op15");
`ifdef DALU_SHR_EN
    issue(1'b0, 4'd8, 8'h03, 8'hFF, 8'h01, 2'b10, "shr_03");
    issue(1'b0, 4'd8, 8'h80, 8'h00, 8'h40, 2'b00, "shr_80");
`else
    issue(1'b0, 4'd8, 8'h03, 8'hFF, 8'h00, 2'b01, "op8_03");
    issue(1'b0, 4'd8, 8'h80, 8'h00, 8'h00, 2'b01, "op8_80");
`endif
    issue(1'b0, 4'd5, 8'd250, 8'd7, 8'h01, 2'b10, "add_before_rst");
    issue(1'b1, 4'd5, 8'd250, 8'd7, 8'h00, 2'b01, "rst_mid_add");
    issue(1'b0, 4'd5, 8'd250, 8'd7, 8'h01, 2'b10, "add_after_rst");
    issue(1'b0, 4'd1, 8'h40, 8'h01, 8'h41, 2'b00, "or_after_add");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
